// File: rtl/alu_fun_encoder.sv
// One-hot ALU unit request encoder feeding a DEPTH-entry command FIFO.
// Optional macro ALU_ENC_ERRCNT_EN adds the saturating Err_Count output.
module alu_fun_encoder #(
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     Req_Valid,
  input  logic [3:0]               Req_OneHot,
  output logic                     Req_Ready,
  output logic [1:0]               ALU_FUN,
  output logic                     ALU_FUN_Valid,
  input  logic                     ALU_Ready,
  output logic [$clog2(DEPTH):0]   Fifo_Count,
`ifdef ALU_ENC_ERRCNT_EN
  output logic [7:0]               Err_Count,
`endif
  output logic                     Err_OneHot
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    FUN_ARITH = 2'b00,
    FUN_LOGIC = 2'b01,
    FUN_CMP   = 2'b10,
    FUN_SHIFT = 2'b11
  } alu_fun_e;

  logic [1:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;

  logic          accept;
  logic          legal;
  logic          push;
  logic          pop;
  alu_fun_e      enc;

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    enc   = FUN_ARITH;
    legal = 1'b1;
    unique case (Req_OneHot)
      4'b0001: enc = FUN_ARITH;
      4'b0010: enc = FUN_LOGIC;
      4'b0100: enc = FUN_CMP;
      4'b1000: enc = FUN_SHIFT;
      default: legal = 1'b0;
    endcase
  end

  // Ready and valid derive from registered occupancy only; no bypass from ALU_Ready.
  assign Req_Ready     = (count_q < DEPTH_C);
  assign ALU_FUN_Valid = (count_q != '0);
  assign ALU_FUN       = ALU_FUN_Valid ? mem_q[rd_ptr_q] : 2'b00;
  assign Fifo_Count    = count_q;
  assign Err_OneHot    = err_q;

  assign accept = Req_Valid & Req_Ready;
  assign push   = accept & legal;
  assign pop    = ALU_FUN_Valid & ALU_Ready;
  assign err_d  = accept & ~legal;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; count_q gates every read of it.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= enc;
  end

`ifdef ALU_ENC_ERRCNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      err_cnt_q <= 8'h00;
    end else if (err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign Err_Count = err_cnt_q;
`endif

endmodule

// File: tb/tb_alu_fun_encoder.sv
// Directed bench for alu_fun_encoder (DEPTH=4); define ALU_ENC_ERRCNT_EN to also check Err_Count.
module tb_alu_fun_encoder;

  logic       CLK;
  logic       RST;
  logic       Req_Valid;
  logic [3:0] Req_OneHot;
  logic       Req_Ready;
  logic [1:0] ALU_FUN;
  logic       ALU_FUN_Valid;
  logic       ALU_Ready;
  logic [2:0] Fifo_Count;
  logic       Err_OneHot;
`ifdef ALU_ENC_ERRCNT_EN
  logic [7:0] Err_Count;
`endif

  int n_vec = 0;
  int n_err = 0;

  alu_fun_encoder #(.DEPTH(4)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .Req_Valid     (Req_Valid),
    .Req_OneHot    (Req_OneHot),
    .Req_Ready     (Req_Ready),
    .ALU_FUN       (ALU_FUN),
    .ALU_FUN_Valid (ALU_FUN_Valid),
    .ALU_Ready     (ALU_Ready),
    .Fifo_Count    (Fifo_Count),
`ifdef ALU_ENC_ERRCNT_EN
    .Err_Count     (Err_Count),
`endif
    .Err_OneHot    (Err_OneHot)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push1(input logic [3:0] oh);
    Req_Valid  = 1'b1;
    Req_OneHot = oh;
    tick();
    Req_Valid  = 1'b0;
  endtask

  // Streaming vectors: one-hot request and its hand-encoded ALU_FUN.
  logic [3:0] str_oh  [10] = '{4'b1000, 4'b0001, 4'b0100, 4'b0010, 4'b0010,
                               4'b1000, 4'b0100, 4'b0001, 4'b1000, 4'b0100};
  logic [1:0] str_fun [10] = '{2'b11, 2'b00, 2'b10, 2'b01, 2'b01,
                               2'b11, 2'b10, 2'b00, 2'b11, 2'b10};

  initial begin
    logic [1:0] exp_q [$];
    logic [1:0] drain_exp [4];

    RST = 1'b0; Req_Valid = 1'b0; Req_OneHot = 4'b0000; ALU_Ready = 1'b0;

    // Reset state
    #3;
    check("rst_count", 32'(Fifo_Count), 32'd0);
    check("rst_valid", 32'(ALU_FUN_Valid), 32'd0);
    check("rst_fun",   32'(ALU_FUN), 32'd0);
    check("rst_err",   32'(Err_OneHot), 32'd0);
`ifdef ALU_ENC_ERRCNT_EN
    check("rst_errcnt", 32'(Err_Count), 32'd0);
`endif
    tick(); tick();
    #2 RST = 1'b1;
    tick();
    check("rst_ready", 32'(Req_Ready), 32'd1);

    // Single push, visible next cycle
    push1(4'b0100);
    check("p1_fun",   32'(ALU_FUN), 32'h2);
    check("p1_valid", 32'(ALU_FUN_Valid), 32'd1);
    check("p1_count", 32'(Fifo_Count), 32'd1);
    tick();
    check("p1_hold_fun", 32'(ALU_FUN), 32'h2);
    ALU_Ready = 1'b1; tick(); ALU_Ready = 1'b0;
    check("p1_drain_count", 32'(Fifo_Count), 32'd0);
    check("p1_drain_fun",   32'(ALU_FUN), 32'd0);

    // Fill to full, then drain in order
    Req_Valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      Req_OneHot = 4'(1 << i);
      tick();
    end
    Req_Valid = 1'b0;
    check("full_count", 32'(Fifo_Count), 32'd4);
    check("full_ready", 32'(Req_Ready), 32'd0);
    tick();
    check("full_hold_fun",   32'(ALU_FUN), 32'h0);
    check("full_hold_count", 32'(Fifo_Count), 32'd4);
    ALU_Ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_fun%0d", i), 32'(ALU_FUN), 32'(i));
      tick();
    end
    ALU_Ready = 1'b0;
    check("drain_count", 32'(Fifo_Count), 32'd0);
    check("drain_valid", 32'(ALU_FUN_Valid), 32'd0);

    // Push against full while popping: push blocked, accepted next cycle
    Req_Valid = 1'b1;
    Req_OneHot = 4'b1000; tick();
    Req_OneHot = 4'b0100; tick();
    Req_OneHot = 4'b0010; tick();
    Req_OneHot = 4'b0001; tick();
    check("fp_ready0", 32'(Req_Ready), 32'd0);
    ALU_Ready = 1'b1;
    tick();
    check("fp_count3", 32'(Fifo_Count), 32'd3);
    check("fp_ready1", 32'(Req_Ready), 32'd1);
    ALU_Ready = 1'b0;
    tick();
    Req_Valid = 1'b0;
    check("fp_count4", 32'(Fifo_Count), 32'd4);
    drain_exp = '{2'b10, 2'b01, 2'b00, 2'b00};
    ALU_Ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("fp_fun%0d", i), 32'(ALU_FUN), 32'(drain_exp[i]));
      tick();
    end
    ALU_Ready = 1'b0;
    check("fp_empty", 32'(Fifo_Count), 32'd0);

    // Illegal requests
    push1(4'b0110);
    check("ill1_err",   32'(Err_OneHot), 32'd1);
    check("ill1_count", 32'(Fifo_Count), 32'd0);
    push1(4'b0000);
    check("ill2_err",   32'(Err_OneHot), 32'd1);
    check("ill2_count", 32'(Fifo_Count), 32'd0);
    tick();
    check("ill_err_clr", 32'(Err_OneHot), 32'd0);
`ifdef ALU_ENC_ERRCNT_EN
    check("errcnt2", 32'(Err_Count), 32'd2);
`endif

    // Illegal push concurrent with pop: only the pop lands
    push1(4'b0010);
    check("ip_count1", 32'(Fifo_Count), 32'd1);
    ALU_Ready = 1'b1;
    push1(4'b1111);
    ALU_Ready = 1'b0;
    check("ip_count0", 32'(Fifo_Count), 32'd0);
    check("ip_err",    32'(Err_OneHot), 32'd1);
`ifdef ALU_ENC_ERRCNT_EN
    Req_Valid = 1'b1; Req_OneHot = 4'b0000;
    for (int i = 0; i < 300; i++) tick();
    Req_Valid = 1'b0;
    tick();
    check("errcnt_sat", 32'(Err_Count), 32'd255);
`endif

    // Streaming push+pop at count 2 across pointer wrap
    push1(4'b0001); exp_q.push_back(2'b00);
    push1(4'b1000); exp_q.push_back(2'b11);
    check("st_count_start", 32'(Fifo_Count), 32'd2);
    Req_Valid = 1'b1; ALU_Ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      Req_OneHot = str_oh[i];
      check($sformatf("st_fun%0d", i), 32'(ALU_FUN), 32'(exp_q.pop_front()));
      exp_q.push_back(str_fun[i]);
      tick();
      check($sformatf("st_count%0d", i), 32'(Fifo_Count), 32'd2);
    end
    Req_Valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("st_tail%0d", i), 32'(ALU_FUN), 32'(exp_q.pop_front()));
      tick();
    end
    ALU_Ready = 1'b0;
    check("st_empty", 32'(Fifo_Count), 32'd0);

    // Reset mid-stream
    push1(4'b0001); push1(4'b0010); push1(4'b0100);
    check("mr_count3", 32'(Fifo_Count), 32'd3);
    #2 RST = 1'b0;
    #1;
    check("mr_count0", 32'(Fifo_Count), 32'd0);
    check("mr_valid0", 32'(ALU_FUN_Valid), 32'd0);
    check("mr_fun0",   32'(ALU_FUN), 32'd0);
    tick();
    #2 RST = 1'b1;
    ALU_Ready = 1'b1;
    tick(); tick();
    check("mr_post_valid", 32'(ALU_FUN_Valid), 32'd0);
    check("mr_post_count", 32'(Fifo_Count), 32'd0);
    ALU_Ready = 1'b0;
    push1(4'b1000);
    check("mr_new_fun",   32'(ALU_FUN), 32'h3);
    check("mr_new_count", 32'(Fifo_Count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
